uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single on-chip UART transmitter between two byte-stream requesters: the CPU memory-mapped UART path (req0) and a hardware status/debug reporter (req1). Grants the transmitter per packet with round-robin fairness, so bytes from different requesters never interleave inside a packet. A burst cap and an idle timeout bound how long either requester can hold the transmitter. Sits between the requesters and the uart_transmitter data_in/valid/ready interface in the CPU clock domain.

Parameters:
MAX_BURST, 16, max bytes per grant before forced release; 0 = unlimited
IDLE_TIMEOUT, 1024, cycles a granted requester may hold the grant with valid low before forced release; 0 = never
CNT_WIDTH, 16, width of the burst and timeout counters; must hold max(MAX_BURST, IDLE_TIMEOUT)

Ports:
clk  input  1  CPU clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_data  input  8  byte from requester 0
req0_valid  input  1  requester 0 byte valid
req0_last  input  1  marks final byte of requester 0 packet
req0_ready  output  1  requester 0 byte accepted this cycle when high with valid
req1_data  input  8  byte from requester 1
req1_valid  input  1  requester 1 byte valid
req1_last  input  1  marks final byte of requester 1 packet
req1_ready  output  1  requester 1 handshake
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  byte valid to UART transmitter
tx_ready  input  1  UART transmitter can accept a byte
grant  output  2  one-hot current owner (bit0 = req0); 2'b00 when idle
busy  output  1  high when grant != 0

Behaviour:
- Single clock, one FSM: IDLE, OWN0, OWN1. Round-robin pointer rr (0 = req0 preferred next).
- Reset (rst high at an edge): state IDLE, rr = 0, burst and timeout counters 0. During and after reset until a grant: grant = 0, busy = 0, tx_valid = 0, tx_data = 0, req0_ready = req1_ready = 0.
- IDLE: if exactly one reqN_valid high -> OWNn next cycle. If both high -> owner is the one selected by rr. Grant latency = 1 cycle from valid sampled in IDLE.
- OWNn, combinational pass-through: tx_data = reqN_data, tx_valid = reqN_valid, reqN_ready = tx_ready; non-owner ready = 0. tx_data = 0 and tx_valid = 0 when idle.
- Beat = tx_valid & tx_ready in an OWN state. Each beat increments the burst counter; the timeout counter clears on a beat or whenever owner valid is high.
- Release conditions, evaluated at the clock edge, transition to IDLE on the next cycle:
  (a) beat with reqN_last = 1;
  (b) MAX_BURST != 0 and this beat is the MAX_BURST-th of the grant;
  (c) IDLE_TIMEOUT != 0 and owner valid has been low for IDLE_TIMEOUT consecutive cycles.
- On release: rr points to the other requester; counters clear. IDLE always lasts at least 1 cycle between grants, with no back-to-back grant.
- The owner holds the grant while valid is low (below timeout), including mid-packet; the other requester waits.
- tx_ready low with valid high: hold; no counters advance; the timeout counter stays cleared.
- A forced release (b or c) does not alter the requester's packet; the remainder is sent at its next grant.
- Reset mid-packet: the grant drops the following cycle; the in-flight byte is not accepted unless the beat occurred before reset.
- last asserted with valid low is ignored.

Test Plan:
- Only req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready = 1 -> grant = 01 one cycle after valid; tx_data shows 41,42,43 on consecutive cycles; grant = 00 the cycle after 0x43.
- Both valid from reset, 2-byte packets each (req0: 0x10,0x11; req1: 0x20,0x21) -> order 10,11, one idle cycle, 20,21; never interleaved; req1_ready stays 0 during req0's grant.
- MAX_BURST = 4, req1 sends a 6-byte packet while req0 waits -> 4 req1 bytes, release, full req0 packet, then the remaining 2 req1 bytes.
- IDLE_TIMEOUT = 8, req0 sends 1 byte without last and then drops valid, with req1 pending -> release after 8 idle cycles; req1 granted 1 cycle later.
- tx_ready toggled 1/0 every cycle during a 4-byte req0 packet -> exactly 4 beats, data stable while stalled, no timeout release.
- rst pulsed for 1 cycle after byte 2 of a 5-byte req1 packet -> next cycle grant = 00, tx_valid = 0, rr = 0; a subsequent simultaneous request is granted to req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter - per-packet round-robin sharing of one UART transmitter
// Rev 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_max_burst    = CNT_WIDTH'(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0] c_idle_timeout = CNT_WIDTH'(IDLE_TIMEOUT);

    state_t               r_state;
    logic                 r_rr;
    logic [1:0]           r_grant;
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_idle_cnt;

    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic                 w_beat;
    logic [CNT_WIDTH-1:0] w_burst_next;
    logic [CNT_WIDTH-1:0] w_idle_next;
    logic                 w_rel_last;
    logic                 w_rel_burst;
    logic                 w_rel_idle;
    logic                 w_release;

    // Pass-through is blanked while rst is high so an in-flight byte is never accepted.
    always_comb begin
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            if (r_grant[0]) begin
                tx_data    = req0_data;
                tx_valid   = req0_valid;
                req0_ready = tx_ready;
            end else if (r_grant[1]) begin
                tx_data    = req1_data;
                tx_valid   = req1_valid;
                req1_ready = tx_ready;
            end
        end
    end

    assign grant = r_grant;
    assign busy  = |r_grant;

    assign w_owner_valid = (r_grant[0] & req0_valid) | (r_grant[1] & req1_valid);
    assign w_owner_last  = (r_grant[0] & req0_last)  | (r_grant[1] & req1_last);
    assign w_beat        = tx_valid & tx_ready;
    assign w_burst_next  = r_burst_cnt + 1'b1;
    assign w_idle_next   = r_idle_cnt + 1'b1;

    assign w_rel_last  = w_beat & w_owner_last;
    assign w_rel_burst = (MAX_BURST != 0) && w_beat && (w_burst_next == c_max_burst);
    assign w_rel_idle  = (IDLE_TIMEOUT != 0) && busy && !w_owner_valid
                         && (w_idle_next == c_idle_timeout);
    assign w_release   = w_rel_last | w_rel_burst | w_rel_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_grant     <= 2'b00;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_valid && (!req1_valid || !r_rr)) begin
                        r_state <= ST_OWN0;
                        r_grant <= 2'b01;
                    end else if (req1_valid) begin
                        r_state <= ST_OWN1;
                        r_grant <= 2'b10;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_release) begin
                        r_state     <= ST_IDLE;
                        r_grant     <= 2'b00;
                        r_rr        <= (r_state == ST_OWN0);
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end else begin
                        if (w_beat)
                            r_burst_cnt <= w_burst_next;
                        // A stalled owner with valid high is not idle.
                        if (w_beat || w_owner_valid)
                            r_idle_cnt <= '0;
                        else
                            r_idle_cnt <= w_idle_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter - directed vector bench for uart_tx_arbiter
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] grant;
    logic       busy;

    uart_tx_arbiter #(
        .MAX_BURST   (4),
        .IDLE_TIMEOUT(8),
        .CNT_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tst;
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       txr;
        logic       chk;
        logic [1:0] g;
        logic       txv;
        logic [7:0] txd;
        logic       r0;
        logic       r1;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;
    int   n_beats;

    task automatic add(input int t, input logic r,
                       input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic txr, input logic chk,
                       input logic [1:0] g, input logic txv, input logic [7:0] txd,
                       input logic r0, input logic r1);
        vec_t v;
        v.tst = t; v.rst = r;
        v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.txr = txr; v.chk = chk;
        v.g = g; v.txv = txv; v.txd = txd; v.r0 = r0; v.r1 = r1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic txr);
        rst = r;
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
        tx_ready = txr;
    endtask

    // Expected output word: {grant, tx_valid, tx_data, req0_ready, req1_ready}
    task automatic check(input string nm, input int idx, input logic [12:0] exp);
        logic [12:0] got;
        got = {grant, tx_valid, tx_data, req0_ready, req1_ready};
        n_checks++;
        if (got !== exp || busy !== (|exp[12:11])) begin
            n_fail++;
            $display("FAIL %s[%0d]: got g=%b v=%b d=%h r0=%b r1=%b busy=%b, need g=%b v=%b d=%h r0=%b r1=%b busy=%b",
                     nm, idx, got[12:11], got[10], got[9:2], got[1], got[0], busy,
                     exp[12:11], exp[10], exp[9:2], exp[1], exp[0], |exp[12:11]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_beats  = 0;
        drive(1'b1, 0, 8'h00, 0, 0, 8'h00, 0, 1'b0);

        // reset
        add(0, 1, 0,8'h00,0, 0,8'h00,0, 0, 0, 2'b00,0,8'h00,0,0);
        add(0, 1, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        // 1: req0 alone, 41 42 43
        add(1, 0, 1,8'h41,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(1, 0, 1,8'h41,0, 0,8'h00,0, 1, 1, 2'b01,1,8'h41,1,0);
        add(1, 0, 1,8'h42,0, 0,8'h00,0, 1, 1, 2'b01,1,8'h42,1,0);
        add(1, 0, 1,8'h43,1, 0,8'h00,0, 1, 1, 2'b01,1,8'h43,1,0);
        add(1, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        // 2: reset, then both valid; req0 first, one idle cycle, then req1
        add(2, 1, 0,8'h00,0, 0,8'h00,0, 1, 0, 2'b00,0,8'h00,0,0);
        add(2, 0, 1,8'h10,0, 1,8'h20,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(2, 0, 1,8'h10,0, 1,8'h20,0, 1, 1, 2'b01,1,8'h10,1,0);
        add(2, 0, 1,8'h11,1, 1,8'h20,0, 1, 1, 2'b01,1,8'h11,1,0);
        add(2, 0, 0,8'h00,0, 1,8'h20,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(2, 0, 0,8'h00,0, 1,8'h20,0, 1, 1, 2'b10,1,8'h20,0,1);
        add(2, 0, 0,8'h00,0, 1,8'h21,1, 1, 1, 2'b10,1,8'h21,0,1);
        add(2, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        // 3: burst cap of 4 on a 6-byte req1 packet, req0 waiting
        add(3, 0, 0,8'h00,0, 1,8'hA0,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(3, 0, 1,8'hB0,0, 1,8'hA0,0, 1, 1, 2'b10,1,8'hA0,0,1);
        add(3, 0, 1,8'hB0,0, 1,8'hA1,0, 1, 1, 2'b10,1,8'hA1,0,1);
        add(3, 0, 1,8'hB0,0, 1,8'hA2,0, 1, 1, 2'b10,1,8'hA2,0,1);
        add(3, 0, 1,8'hB0,0, 1,8'hA3,0, 1, 1, 2'b10,1,8'hA3,0,1);
        add(3, 0, 1,8'hB0,0, 1,8'hA4,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(3, 0, 1,8'hB0,0, 1,8'hA4,0, 1, 1, 2'b01,1,8'hB0,1,0);
        add(3, 0, 1,8'hB1,1, 1,8'hA4,0, 1, 1, 2'b01,1,8'hB1,1,0);
        add(3, 0, 0,8'h00,0, 1,8'hA4,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(3, 0, 0,8'h00,0, 1,8'hA4,0, 1, 1, 2'b10,1,8'hA4,0,1);
        add(3, 0, 0,8'h00,0, 1,8'hA5,1, 1, 1, 2'b10,1,8'hA5,0,1);
        add(3, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        // 4: idle timeout of 8 with req1 pending; last with valid low is ignored
        add(4, 0, 1,8'hC0,0, 1,8'hD0,1, 1, 1, 2'b00,0,8'h00,0,0);
        add(4, 0, 1,8'hC0,0, 1,8'hD0,1, 1, 1, 2'b01,1,8'hC0,1,0);
        for (int i = 0; i < 8; i++)
            add(4, 0, 0,8'h00,1, 1,8'hD0,1, 1, 1, 2'b01,0,8'h00,1,0);
        add(4, 0, 0,8'h00,0, 1,8'hD0,1, 1, 1, 2'b00,0,8'h00,0,0);
        add(4, 0, 0,8'h00,0, 1,8'hD0,1, 1, 1, 2'b10,1,8'hD0,0,1);
        add(4, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        // 5: tx_ready toggling during a 4-byte req0 packet
        add(5, 0, 1,8'hE0,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(5, 0, 1,8'hE0,0, 0,8'h00,0, 0, 1, 2'b01,1,8'hE0,0,0);
        add(5, 0, 1,8'hE0,0, 0,8'h00,0, 1, 1, 2'b01,1,8'hE0,1,0);
        add(5, 0, 1,8'hE1,0, 0,8'h00,0, 0, 1, 2'b01,1,8'hE1,0,0);
        add(5, 0, 1,8'hE1,0, 0,8'h00,0, 1, 1, 2'b01,1,8'hE1,1,0);
        add(5, 0, 1,8'hE2,0, 0,8'h00,0, 0, 1, 2'b01,1,8'hE2,0,0);
        add(5, 0, 1,8'hE2,0, 0,8'h00,0, 1, 1, 2'b01,1,8'hE2,1,0);
        add(5, 0, 1,8'hE3,1, 0,8'h00,0, 0, 1, 2'b01,1,8'hE3,0,0);
        add(5, 0, 1,8'hE3,1, 0,8'h00,0, 1, 1, 2'b01,1,8'hE3,1,0);
        add(5, 0, 0,8'h00,0, 0,8'h00,0, 0, 1, 2'b00,0,8'h00,0,0);
        // 6: reset after byte 2 of a req1 packet; rr back to req0
        add(6, 0, 0,8'h00,0, 1,8'hF0,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(6, 0, 0,8'h00,0, 1,8'hF0,0, 1, 1, 2'b10,1,8'hF0,0,1);
        add(6, 0, 0,8'h00,0, 1,8'hF1,0, 1, 1, 2'b10,1,8'hF1,0,1);
        add(6, 1, 0,8'h00,0, 1,8'hF2,0, 1, 0, 2'b00,0,8'h00,0,0);
        add(6, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);
        add(6, 0, 1,8'h60,1, 1,8'hF2,1, 1, 1, 2'b00,0,8'h00,0,0);
        add(6, 0, 1,8'h60,1, 1,8'hF2,1, 1, 1, 2'b01,1,8'h60,1,0);
        add(6, 0, 0,8'h00,0, 1,8'hF2,1, 1, 1, 2'b00,0,8'h00,0,0);
        add(6, 0, 0,8'h00,0, 1,8'hF2,1, 1, 1, 2'b10,1,8'hF2,0,1);
        add(6, 0, 0,8'h00,0, 0,8'h00,0, 1, 1, 2'b00,0,8'h00,0,0);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].v0, vecs[k].d0, vecs[k].l0,
                  vecs[k].v1, vecs[k].d1, vecs[k].l1, vecs[k].txr);
            #1;
            if (vecs[k].chk)
                check($sformatf("t%0d_vec", vecs[k].tst), k,
                      {vecs[k].g, vecs[k].txv, vecs[k].txd, vecs[k].r0, vecs[k].r1});
            if (tx_valid && tx_ready)
                n_beats++;
        end

        // Owner stalled by tx_ready low for longer than the idle timeout keeps the grant.
        @(negedge clk);
        drive(1'b0, 1, 8'h77, 1, 1, 8'h88, 1, 1'b0);
        #1;
        check("stall_idle", 0, {2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, 1, 8'h77, 1, 1, 8'h88, 1, 1'b0);
            #1;
            check("stall_hold", i, {2'b01, 1'b1, 8'h77, 1'b0, 1'b0});
        end
        @(negedge clk);
        drive(1'b0, 1, 8'h77, 1, 1, 8'h88, 1, 1'b1);
        #1;
        check("stall_beat", 0, {2'b01, 1'b1, 8'h77, 1'b1, 1'b0});
        if (tx_valid && tx_ready)
            n_beats++;
        @(negedge clk);
        drive(1'b0, 0, 8'h00, 0, 1, 8'h88, 1, 1'b1);
        #1;
        check("stall_release", 0, {2'b00, 1'b0, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        drive(1'b0, 0, 8'h00, 0, 1, 8'h88, 1, 1'b1);
        #1;
        check("stall_next", 0, {2'b10, 1'b1, 8'h88, 1'b0, 1'b1});
        if (tx_valid && tx_ready)
            n_beats++;
        @(negedge clk);
        drive(1'b0, 0, 8'h00, 0, 0, 8'h00, 0, 1'b1);

        n_checks++;
        if (n_beats != 27) begin
            n_fail++;
            $display("FAIL beat_total: got %0d beats, need 27", n_beats);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
